// File: rtl/test_engine_sequencer_pkg.sv
// Shared definitions for the test engine sequencer: data width, FSM encoding, timeout fill.
// DATA_WIDTH derives from `CHANNEL_WIDTH (defaults to 32 when the build does not set it).
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 32
`endif

package test_engine_sequencer_pkg;

   localparam int unsigned DATA_WIDTH = 2 * `CHANNEL_WIDTH;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StWait  = 2'd2,
      StHold  = 2'd3
   } state_e;

   // Every bit of a timed-out result word takes this value.
   localparam logic TIMEOUT_FILL_BIT = 1'b1;

endpackage

// File: rtl/test_engine_watchdog.sv
// WAIT-state cycle counter with expiry compare; used by test_engine_sequencer only when
// TEST_ENGINE_TIMEOUT_EN is defined.
module test_engine_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (run && !expired) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Fires during the TIMEOUT_CYCLES-th WAIT cycle, so the sequencer leaves on that edge.
   assign expired = run && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/test_engine_sequencer.sv
// Single-job sequencer between NIC input buffer, test engine and NIC output buffer.
// Optional watchdog and sticky timeout_dout enabled by TEST_ENGINE_TIMEOUT_EN.
module test_engine_sequencer
   import test_engine_sequencer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = test_engine_sequencer_pkg::DATA_WIDTH,
   parameter int unsigned COUNT_WIDTH    = 16,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid_din,
   input  logic [DATA_WIDTH-1:0]  in_wordA_din,
   input  logic [DATA_WIDTH-1:0]  in_wordB_din,
   output logic                   in_ready_dout,
   output logic                   start_strobe_dout,
   output logic [DATA_WIDTH-1:0]  wordA_dout,
   output logic [DATA_WIDTH-1:0]  wordB_dout,
   input  logic                   done_strobe_din,
   input  logic                   active_test_engine_din,
   input  logic [DATA_WIDTH-1:0]  wordC_din,
   input  logic [DATA_WIDTH-1:0]  wordD_din,
   output logic                   out_valid_dout,
   output logic [DATA_WIDTH-1:0]  out_wordC_dout,
   output logic [DATA_WIDTH-1:0]  out_wordD_dout,
   input  logic                   out_ack_din,
   output logic                   busy_dout,
   output logic [COUNT_WIDTH-1:0] job_count_dout
`ifdef TEST_ENGINE_TIMEOUT_EN
   ,
   output logic                   timeout_dout
`endif
);

   state_e                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  op_a_q, op_a_d;
   logic [DATA_WIDTH-1:0]  op_b_q, op_b_d;
   logic [DATA_WIDTH-1:0]  res_c_q, res_c_d;
   logic [DATA_WIDTH-1:0]  res_d_q, res_d_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;

   // Engine busy is informational only; it never gates the sequence.
   logic unused_active;
   assign unused_active = active_test_engine_din;

`ifdef TEST_ENGINE_TIMEOUT_EN
   logic wd_expired;
   logic timeout_q, timeout_d;

   test_engine_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state_q == StStart),
      .run     (state_q == StWait),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
      end
   end

   assign timeout_dout = timeout_q;
`endif

   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      res_c_d = res_c_q;
      res_d_d = res_d_q;
      count_d = count_q;
`ifdef TEST_ENGINE_TIMEOUT_EN
      timeout_d = timeout_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (in_valid_din) begin
               op_a_d  = in_wordA_din;
               op_b_d  = in_wordB_din;
               state_d = StStart;
            end
         end
         StStart: state_d = StWait;
         StWait: begin
            // A real completion takes priority over a simultaneous watchdog expiry.
            if (done_strobe_din) begin
               res_c_d = wordC_din;
               res_d_d = wordD_din;
               count_d = count_q + COUNT_WIDTH'(1);
               state_d = StHold;
            end
`ifdef TEST_ENGINE_TIMEOUT_EN
            else if (wd_expired) begin
               res_c_d   = {DATA_WIDTH{TIMEOUT_FILL_BIT}};
               res_d_d   = {DATA_WIDTH{TIMEOUT_FILL_BIT}};
               timeout_d = 1'b1;
               state_d   = StHold;
            end
`endif
         end
         StHold: begin
            if (out_ack_din) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         op_a_q  <= '0;
         op_b_q  <= '0;
         res_c_q <= '0;
         res_d_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         res_c_q <= res_c_d;
         res_d_q <= res_d_d;
         count_q <= count_d;
      end
   end

   assign in_ready_dout     = (state_q == StIdle);
   assign start_strobe_dout = (state_q == StStart);
   assign out_valid_dout    = (state_q == StHold);
   assign busy_dout         = (state_q != StIdle);
   assign wordA_dout        = op_a_q;
   assign wordB_dout        = op_b_q;
   assign out_wordC_dout    = res_c_q;
   assign out_wordD_dout    = res_d_q;
   assign job_count_dout    = count_q;

endmodule

// File: tb/tb_test_engine_sequencer.sv
// Self-checking bench for test_engine_sequencer: vector table plus directed multi-cycle sequences.
// Covers the TEST_ENGINE_TIMEOUT_EN watchdog when that macro is defined.
module tb_test_engine_sequencer;
   import test_engine_sequencer_pkg::*;

   localparam int DW = DATA_WIDTH;
   localparam int CW = 16;
   localparam int NV = 12;

   logic          clk, reset_n;
   logic          in_valid_din, in_ready_dout, start_strobe_dout;
   logic [DW-1:0] in_wordA_din, in_wordB_din, wordA_dout, wordB_dout;
   logic          done_strobe_din, active_test_engine_din;
   logic [DW-1:0] wordC_din, wordD_din, out_wordC_dout, out_wordD_dout;
   logic          out_valid_dout, out_ack_din, busy_dout;
   logic [CW-1:0] job_count_dout;
`ifdef TEST_ENGINE_TIMEOUT_EN
   logic          timeout_dout;
`endif

   test_engine_sequencer #(
      .DATA_WIDTH     (DW),
      .COUNT_WIDTH    (CW),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk                    (clk),
      .reset_n                (reset_n),
      .in_valid_din           (in_valid_din),
      .in_wordA_din           (in_wordA_din),
      .in_wordB_din           (in_wordB_din),
      .in_ready_dout          (in_ready_dout),
      .start_strobe_dout      (start_strobe_dout),
      .wordA_dout             (wordA_dout),
      .wordB_dout             (wordB_dout),
      .done_strobe_din        (done_strobe_din),
      .active_test_engine_din (active_test_engine_din),
      .wordC_din              (wordC_din),
      .wordD_din              (wordD_din),
      .out_valid_dout         (out_valid_dout),
      .out_wordC_dout         (out_wordC_dout),
      .out_wordD_dout         (out_wordD_dout),
      .out_ack_din            (out_ack_din),
      .busy_dout              (busy_dout),
      .job_count_dout         (job_count_dout)
`ifdef TEST_ENGINE_TIMEOUT_EN
      ,
      .timeout_dout           (timeout_dout)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          v;
      logic [DW-1:0] a, b;
      logic          dn;
      logic [DW-1:0] c, d;
      logic          ack, act;
      logic [19:0]   e_st;   // {ready, start, out_valid, busy, count}
      logic [DW-1:0] e_wa, e_wb, e_oc, e_od;
   } vec_t;

   vec_t tbl [NV];
   int   n_cmp = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic logic [19:0] st_act();
      return {in_ready_dout, start_strobe_dout, out_valid_dout, busy_dout, job_count_dout};
   endfunction

   function automatic logic [19:0] st(input logic r, s, o, b, input logic [15:0] c);
      return {r, s, o, b, c};
   endfunction

   function automatic vec_t mk(input logic v, input logic [DW-1:0] a, b, input logic dn,
                               input logic [DW-1:0] c, d, input logic ack, act,
                               input logic [19:0] e_st, input logic [DW-1:0] wa, wb, oc, od);
      vec_t t;
      t.v = v; t.a = a; t.b = b; t.dn = dn; t.c = c; t.d = d; t.ack = ack; t.act = act;
      t.e_st = e_st; t.e_wa = wa; t.e_wb = wb; t.e_oc = oc; t.e_od = od;
      return t;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid_din = 0; in_wordA_din = '0; in_wordB_din = '0;
      done_strobe_din = 0; active_test_engine_din = 0;
      wordC_din = '0; wordD_din = '0; out_ack_din = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 0;
      #12;
      reset_n = 1;
      step();
   endtask

   // Accepts A/B, runs WAIT for wait_cycles, returns C/D with done; leaves DUT in HOLD.
   task automatic run_job(input logic [DW-1:0] a, b, c, d, input int wait_cycles);
      in_valid_din = 1; in_wordA_din = a; in_wordB_din = b;
      step();
      in_valid_din = 0;
      repeat (wait_cycles + 1) step();
      done_strobe_din = 1; wordC_din = c; wordD_din = d;
      step();
      done_strobe_din = 0;
   endtask

   initial begin
      int nstb, nov;
      reset_n = 1;
      idle_inputs();

      // Reset and idle
      do_reset();
      for (int i = 0; i < 10; i++) begin
         chk("reset_idle_status", st_act(), st(1, 0, 0, 0, 0));
         chk("reset_idle_words", {wordA_dout, out_wordC_dout}, '0);
         step();
      end

      // Vector table: expected outputs after the edge that samples each row's inputs
      tbl[0]  = mk(0, 0, 0, 1, 'hee, 'hee, 0, 0, st(1, 0, 0, 0, 0), 0, 0, 0, 0);
      tbl[1]  = mk(1, 5, 7, 0, 0, 0, 0, 0, st(0, 1, 0, 1, 0), 5, 7, 0, 0);
      tbl[2]  = mk(1, 9, 9, 0, 0, 0, 0, 0, st(0, 0, 0, 1, 0), 5, 7, 0, 0);
      tbl[3]  = mk(0, 0, 0, 1, 3, 4, 0, 1, st(0, 0, 1, 1, 1), 5, 7, 3, 4);
      tbl[4]  = mk(0, 0, 0, 1, 8, 8, 0, 0, st(0, 0, 1, 1, 1), 5, 7, 3, 4);
      tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 0, st(1, 0, 0, 0, 1), 5, 7, 3, 4);
      tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 0, st(1, 0, 0, 0, 1), 5, 7, 3, 4);
      tbl[7]  = mk(1, 'ha, 'hb, 0, 0, 0, 0, 0, st(0, 1, 0, 1, 1), 'ha, 'hb, 3, 4);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, st(0, 0, 0, 1, 1), 'ha, 'hb, 3, 4);
      tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 1, st(0, 0, 0, 1, 1), 'ha, 'hb, 3, 4);
      tbl[10] = mk(0, 0, 0, 1, 'hff, 1, 0, 1, st(0, 0, 1, 1, 2), 'ha, 'hb, 'hff, 1);
      tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, st(1, 0, 0, 0, 2), 'ha, 'hb, 'hff, 1);
      for (int i = 0; i < NV; i++) begin
         in_valid_din = tbl[i].v; in_wordA_din = tbl[i].a; in_wordB_din = tbl[i].b;
         done_strobe_din = tbl[i].dn; wordC_din = tbl[i].c; wordD_din = tbl[i].d;
         out_ack_din = tbl[i].ack; active_test_engine_din = tbl[i].act;
         step();
         chk($sformatf("vec%0d_status", i), st_act(), tbl[i].e_st);
         chk($sformatf("vec%0d_operands", i), {wordA_dout, wordB_dout}, {tbl[i].e_wa, tbl[i].e_wb});
         chk($sformatf("vec%0d_results", i), {out_wordC_dout, out_wordD_dout},
             {tbl[i].e_oc, tbl[i].e_od});
      end

      // Single job, engine responds 17 cycles after start with C=B, D=A
      do_reset();
      in_valid_din = 1; in_wordA_din = 'h1111; in_wordB_din = 'h2222;
      step();
      in_valid_din = 0;
      chk("single_start", st_act(), st(0, 1, 0, 1, 0));
      nstb = 0; nov = 0;
      for (int i = 0; i < 17; i++) begin
         step();
         nstb += int'(start_strobe_dout);
         nov  += int'(out_valid_dout);
      end
      chk("single_extra_start", nstb, 0);
      chk("single_early_valid", nov, 0);
      chk("single_operands_wait", {wordA_dout, wordB_dout}, {DW'('h1111), DW'('h2222)});
      done_strobe_din = 1; wordC_din = 'h2222; wordD_din = 'h1111;
      step();
      done_strobe_din = 0; wordC_din = '0; wordD_din = '0;
      chk("single_result", {out_wordC_dout, out_wordD_dout}, {DW'('h2222), DW'('h1111)});

      // Back-pressure with a new pair waiting
      in_valid_din = 1; in_wordA_din = 'h3333; in_wordB_din = 'h4444;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("bp_status", st_act(), st(0, 0, 1, 1, 1));
         chk("bp_result", {out_wordC_dout, out_wordD_dout}, {DW'('h2222), DW'('h1111)});
      end
      out_ack_din = 1;
      step();
      out_ack_din = 0;
      chk("bp_after_ack", st_act(), st(1, 0, 0, 0, 1));
      step();
      in_valid_din = 0;
      chk("bp_second_start", st_act(), st(0, 1, 0, 1, 1));
      chk("bp_second_operands", {wordA_dout, wordB_dout}, {DW'('h3333), DW'('h4444)});
      repeat (3) step();
      done_strobe_din = 1; wordC_din = 'h5555; wordD_din = 'h6666;
      step();
      done_strobe_din = 0;
      chk("bp_second_done", st_act(), st(0, 0, 1, 1, 2));
      // Spurious done in HOLD must not disturb the held result
      done_strobe_din = 1; wordC_din = 'h7777; wordD_din = 'h7777;
      step();
      done_strobe_din = 0;
      chk("hold_spurious_done", {out_wordC_dout, out_wordD_dout}, {DW'('h5555), DW'('h6666)});
      out_ack_din = 1;
      step();
      out_ack_din = 0;
      chk("bp_count_two", st_act(), st(1, 0, 0, 0, 2));

      // Reset during WAIT; a late done must be ignored
      in_valid_din = 1; in_wordA_din = 'h8; in_wordB_din = 'h9;
      step();
      in_valid_din = 0;
      repeat (2) step();
      chk("rst_wait_busy", st_act(), st(0, 0, 0, 1, 2));
      #2 reset_n = 0;
      #2 reset_n = 1;
      chk("rst_wait_cleared", st_act(), st(1, 0, 0, 0, 0));
      done_strobe_din = 1; wordC_din = 'hdead; wordD_din = 'hbeef;
      step();
      done_strobe_din = 0;
      chk("rst_late_done", st_act(), st(1, 0, 0, 0, 0));
      chk("rst_late_done_words", {out_wordC_dout, out_wordD_dout}, '0);
      run_job('h21, 'h22, 'h23, 'h24, 2);
      chk("rst_next_job", st_act(), st(0, 0, 1, 1, 1));
      chk("rst_next_result", {out_wordC_dout, out_wordD_dout}, {DW'('h23), DW'('h24)});
      out_ack_din = 1;
      step();
      out_ack_din = 0;

`ifdef TEST_ENGINE_TIMEOUT_EN
      // Engine never responds: HOLD after 64 WAIT cycles with all-ones words
      chk("to_clear_before", timeout_dout, 0);
      in_valid_din = 1; in_wordA_din = 'h31; in_wordB_din = 'h32;
      step();
      in_valid_din = 0;
      repeat (64) step();
      chk("to_not_yet", st_act(), st(0, 0, 0, 1, 1));
      step();
      chk("to_fired", st_act(), st(0, 0, 1, 1, 1));
      chk("to_fill", {out_wordC_dout, out_wordD_dout}, {(2 * DW){1'b1}});
      chk("to_sticky", timeout_dout, 1);
      out_ack_din = 1;
      step();
      out_ack_din = 0;
      chk("to_sticky_after_ack", timeout_dout, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/test_engine_sequencer.md
Name: test_engine_sequencer

Overview:
- Sequences one test engine on behalf of the NIC.
- Accepts operand pairs (wordA, wordB) from the NIC input side over a valid/ready handshake, fires the engine's start strobe and tracks completion.
- Captures the engine's wordC/wordD results and presents them to the NIC output side over a valid/ack handshake.
- Single outstanding job; sits between NIC input buffer, test engine and NIC output buffer.

Parameters:
- DATA_WIDTH, 2*`CHANNEL_WIDTH, width of every operand/result word.
- COUNT_WIDTH, 16, width of completed-job counter.
- TIMEOUT_CYCLES, 64, watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid_din  in  1  operand pair valid.
- in_wordA_din  in  DATA_WIDTH  operand A.
- in_wordB_din  in  DATA_WIDTH  operand B.
- in_ready_dout  out  1  sequencer can accept a pair.
- start_strobe_dout  out  1  one-cycle start pulse to engine.
- wordA_dout  out  DATA_WIDTH  operand A to engine.
- wordB_dout  out  DATA_WIDTH  operand B to engine.
- done_strobe_din  in  1  engine completion pulse.
- active_test_engine_din  in  1  engine busy indication.
- wordC_din  in  DATA_WIDTH  engine result C.
- wordD_din  in  DATA_WIDTH  engine result D.
- out_valid_dout  out  1  result pair valid.
- out_wordC_dout  out  DATA_WIDTH  result C.
- out_wordD_dout  out  DATA_WIDTH  result D.
- out_ack_din  in  1  consumer takes result.
- busy_dout  out  1  job in flight (state != IDLE).
- job_count_dout  out  COUNT_WIDTH  completed jobs.

Behaviour:
- Reset (reset_n low, async):
  - State returns to IDLE.
  - All outputs 0; operand/result registers 0; counter 0.
  - Reset mid-job abandons the job; no result is emitted and any later done_strobe_din is ignored.
- FSM states: IDLE, START, WAIT, HOLD.
- IDLE:
  - in_ready_dout = 1 (registered/derived from state only, not from in_valid_din).
  - in_valid_din & in_ready_dout at a rising edge latches A/B into the operand registers and moves to START.
- START:
  - start_strobe_dout = 1 for exactly one cycle.
  - Unconditionally moves to WAIT.
- WAIT:
  - wordA_dout/wordB_dout stay stable from START until leaving WAIT.
  - done_strobe_din = 1 captures wordC_din/wordD_din into the result registers, increments job_count_dout (wraps modulo 2^COUNT_WIDTH) and moves to HOLD.
- HOLD:
  - out_valid_dout = 1; result words held stable.
  - out_ack_din = 1 moves to IDLE (out_valid_dout falls on the next cycle).
  - in_ready_dout rises the cycle after ack, so back-to-back jobs cost one IDLE cycle.
- done_strobe_din outside WAIT is ignored; it has no effect on state or counter.
- active_test_engine_din is status only; it does not gate transitions.
- in_ready_dout = 0 in START/WAIT/HOLD; in_valid_din there is ignored (producer must hold).
- Latency: accept edge -> start_strobe_dout high next cycle; done edge -> out_valid_dout high next cycle.
- out_ack_din while out_valid_dout = 0 is ignored.

Optional Feature:
- Macro: TEST_ENGINE_TIMEOUT_EN.
- Defined:
  - A WAIT-state cycle counter, cleared on entering WAIT.
  - If it reaches TIMEOUT_CYCLES with no done, go to HOLD with out_wordC_dout/out_wordD_dout = all ones and out_valid_dout = 1.
  - Sticky output timeout_dout (1 bit) set; cleared only by reset.
  - job_count_dout not incremented on timeout.
  - done and timeout in the same cycle: done wins.
- Undefined: no counter, no timeout_dout port; WAIT waits forever.

Decomposition:
- Shared package/header (system.vh): DATA_WIDTH derivation from `CHANNEL_WIDTH, FSM state encodings (IDLE=2'd0, START=2'd1, WAIT=2'd2, HOLD=2'd3), timeout fill pattern.
- One sub-module is natural: test_engine_watchdog (counter + expiry compare), instantiated only under TEST_ENGINE_TIMEOUT_EN.

Test Plan:
- Reset, then check outputs; release and hold in_valid_din=0 for 10 cycles -> in_ready_dout=1, all other outputs 0, busy_dout=0.
- Single job: A=64'h1111, B=64'h2222; engine model returns done 17 cycles after start with C=B, D=A -> exactly one start pulse, out_valid_dout with C=64'h2222, D=64'h1111, job_count_dout=1 after ack.
- Back-pressure: hold out_ack_din=0 for 20 cycles, with in_valid_din=1 carrying a new pair -> result stable, in_ready_dout=0, no second start; after ack second job runs, count=2.
- Spurious done_strobe_din pulses in IDLE and HOLD -> no state change, count unchanged, result words unchanged.
- Reset pulse during WAIT, then done arrives -> no out_valid_dout, count=0, next job runs normally.
- With TEST_ENGINE_TIMEOUT_EN and TIMEOUT_CYCLES=64, engine never responds -> after 64 WAIT cycles out_valid_dout=1 with all-ones words, timeout_dout=1, count unchanged.
